// File: rtl/irq_controller_if.sv
// Interrupt controller bus: device lines, software register writes,
// and the Ireq/Iack handshake with the control FSM.
interface irq_controller_if #(
    parameter int N_IRQ = 8,
    parameter int ID_W  = 3
);
    logic [N_IRQ-1:0] irq_in;
    logic             mask_we;
    logic [N_IRQ-1:0] mask_wdata;
    logic             pend_clr_we;
    logic [N_IRQ-1:0] pend_clr;
    logic             WriteIen;
    logic             Int_en;
    logic             Iack;
    logic             Ireq;
    logic [ID_W-1:0]  irq_id;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] mask;
    logic             ien;

    modport slave (
        input  irq_in, mask_we, mask_wdata, pend_clr_we, pend_clr,
        input  WriteIen, Int_en, Iack,
        output Ireq, irq_id, pending, mask, ien
    );

    modport master (
        output irq_in, mask_we, mask_wdata, pend_clr_we, pend_clr,
        output WriteIen, Int_en, Iack,
        input  Ireq, irq_id, pending, mask, ien
    );
endinterface

// File: rtl/irq_controller.sv
// Interrupt front-end: line sync, edge-latched pending, mask, global
// enable, fixed-priority grant and Ireq/Iack handshake.
module irq_controller #(
    parameter int N_IRQ = 8,
    parameter int ID_W  = 3
) (
    input  logic            clk,
    input  logic            reset,
    irq_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

    state_e           state_q;
    logic [N_IRQ-1:0] s1_q, s2_q, s3_q;
    logic [N_IRQ-1:0] pend_q, pend_d;
    logic [N_IRQ-1:0] mask_q, mask_d;
    logic [N_IRQ-1:0] rise, clr, act;
    logic             ien_q, ien_d;
    logic             ireq_q;
    logic [ID_W-1:0]  id_q, win;
    logic             ack_fire, has_win;

    assign rise     = s2_q & ~s3_q;
    assign ack_fire = (state_q == REQ) && bus.Iack;
    assign act      = pend_q & mask_q;
    assign has_win  = |act;

    // Set beats clear: rise is OR'd after the clear is applied.
    always_comb begin
        clr = '0;
        if (bus.pend_clr_we) clr = bus.pend_clr;
        if (ack_fire) clr = clr | (N_IRQ'(1) << id_q);
        pend_d = rise | (pend_q & ~clr);
        mask_d = bus.mask_we ? bus.mask_wdata : mask_q;
        ien_d  = ien_q;
        if (bus.WriteIen) ien_d = bus.Int_en;
        else if (ack_fire) ien_d = 1'b0;
    end

    // Scan high to low so the lowest active index wins.
    always_comb begin
        win = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (act[i]) win = ID_W'(i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
            pend_q <= '0;
            mask_q <= '0;
            ien_q  <= 1'b0;
        end else begin
            s1_q   <= bus.irq_in;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            pend_q <= pend_d;
            mask_q <= mask_d;
            ien_q  <= ien_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ireq_q  <= 1'b0;
            id_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ien_q && has_win) begin
                        id_q    <= win;
                        ireq_q  <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (bus.Iack) begin
                        ireq_q  <= 1'b0;
                        state_q <= SERVICE;
                    end else if (bus.WriteIen && !bus.Int_en) begin
                        ireq_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                SERVICE: begin
                    if (ien_q) state_q <= IDLE;
                end
                default: begin
                    ireq_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.Ireq    = ireq_q;
    assign bus.irq_id  = id_q;
    assign bus.pending = pend_q;
    assign bus.mask    = mask_q;
    assign bus.ien     = ien_q;
endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with an expected-grant scoreboard.
module tb_irq_controller;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [2:0] exp_q[$];

    irq_controller_if #(.N_IRQ(8), .ID_W(3)) bus ();

    irq_controller #(.N_IRQ(8), .ID_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [2:0] e;
        total++;
        assert (exp_q.size() > 0) else begin
            bad++;
            $error("FAIL %s observed=grant expected=no_grant", tag);
            return;
        end
        e = exp_q.pop_front();
        chk(tag, 32'(bus.irq_id), 32'(e));
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (bus.Ireq === 1'b1) break;
            step();
        end
        chk({tag, "_req"}, 32'(bus.Ireq), 32'd1);
        pop_chk({tag, "_id"});
    endtask

    task automatic do_iack();
        bus.Iack = 1'b1;
        step();
        bus.Iack = 1'b0;
    endtask

    task automatic set_ien(input logic v);
        bus.WriteIen = 1'b1;
        bus.Int_en   = v;
        step();
        bus.WriteIen = 1'b0;
        bus.Int_en   = 1'b0;
    endtask

    task automatic set_mask(input logic [7:0] m);
        bus.mask_we    = 1'b1;
        bus.mask_wdata = m;
        step();
        bus.mask_we    = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        bus.irq_in      = '0;
        bus.mask_we     = 1'b0;
        bus.mask_wdata  = '0;
        bus.pend_clr_we = 1'b0;
        bus.pend_clr    = '0;
        bus.WriteIen    = 1'b0;
        bus.Int_en      = 1'b0;
        bus.Iack        = 1'b0;
        #3;
        chk("rst_ireq", 32'(bus.Ireq), 0);
        chk("rst_id", 32'(bus.irq_id), 0);
        chk("rst_pend", 32'(bus.pending), 0);
        chk("rst_mask", 32'(bus.mask), 0);
        chk("rst_ien", 32'(bus.ien), 0);
        step();
        reset = 1'b0;
        step();

        // Enable everything
        bus.WriteIen   = 1'b1;
        bus.Int_en     = 1'b1;
        bus.mask_we    = 1'b1;
        bus.mask_wdata = 8'hFF;
        step();
        bus.WriteIen = 1'b0;
        bus.mask_we  = 1'b0;
        chk("en_ien", 32'(bus.ien), 1);
        chk("en_mask", 32'(bus.mask), 32'hFF);

        // Line 5: exact latency, level held high
        bus.irq_in = 8'h20;
        exp_q.push_back(3'd5);
        step();
        step();
        chk("t1_pend_e2", 32'(bus.pending), 0);
        step();
        chk("t1_pend_e3", 32'(bus.pending), 32'h20);
        chk("t1_ireq_e3", 32'(bus.Ireq), 0);
        step();
        chk("t1_ireq_e4", 32'(bus.Ireq), 1);
        pop_chk("t1_id");
        do_iack();
        chk("t1_ack_ireq", 32'(bus.Ireq), 0);
        chk("t1_ack_pend", 32'(bus.pending), 0);
        chk("t1_ack_ien", 32'(bus.ien), 0);
        repeat (4) step();
        chk("t1_level_pend", 32'(bus.pending), 0);
        bus.irq_in = '0;
        set_ien(1'b1);
        repeat (3) step();

        // Lines 2 and 6 together: priority then second grant after eret
        bus.irq_in = 8'h44;
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd6);
        wait_req("t2a");
        chk("t2_pend", 32'(bus.pending), 32'h44);
        do_iack();
        chk("t2_pend_after", 32'(bus.pending), 32'h40);
        chk("t2_ireq_off", 32'(bus.Ireq), 0);
        set_ien(1'b1);
        wait_req("t2b");
        do_iack();
        chk("t2_pend_empty", 32'(bus.pending), 0);
        bus.irq_in = '0;
        set_ien(1'b1);
        repeat (3) step();

        // Masked line 3 becomes visible after mask write
        set_mask(8'h00);
        bus.irq_in = 8'h08;
        repeat (4) step();
        chk("t3_pend", 32'(bus.pending), 32'h08);
        chk("t3_masked", 32'(bus.Ireq), 0);
        exp_q.push_back(3'd3);
        set_mask(8'h08);
        step();
        chk("t3_ireq", 32'(bus.Ireq), 1);
        pop_chk("t3_id");

        // Syscall-style disable while in REQ, then re-enable
        set_ien(1'b0);
        chk("t4_ireq", 32'(bus.Ireq), 0);
        chk("t4_pend", 32'(bus.pending), 32'h08);
        chk("t4_ien", 32'(bus.ien), 0);
        exp_q.push_back(3'd3);
        set_ien(1'b1);
        wait_req("t4");
        do_iack();
        bus.irq_in = '0;
        set_ien(1'b1);
        set_mask(8'h00);
        repeat (3) step();

        // Set wins over software clear on line 4
        bus.irq_in = 8'h10;
        step();
        step();
        bus.pend_clr_we = 1'b1;
        bus.pend_clr    = 8'h10;
        step();
        bus.pend_clr_we = 1'b0;
        chk("t5_setwins", 32'(bus.pending), 32'h10);
        bus.pend_clr_we = 1'b1;
        step();
        bus.pend_clr_we = 1'b0;
        bus.pend_clr    = '0;
        chk("t5_clr", 32'(bus.pending), 0);

        // Asynchronous reset while requesting
        set_mask(8'hFF);
        bus.irq_in = 8'h02;
        exp_q.push_back(3'd1);
        wait_req("t6");
        #2;
        reset = 1'b1;
        #1;
        chk("t6_ireq", 32'(bus.Ireq), 0);
        chk("t6_pend", 32'(bus.pending), 0);
        chk("t6_mask", 32'(bus.mask), 0);
        chk("t6_ien", 32'(bus.ien), 0);
        step();
        reset = 1'b0;
        step();

        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
